// File: rtl/score_overlay.sv
// Score text overlay: per-frame binary-to-BCD conversion of N_FIELDS scores and a
// 2-stage pixel pipeline that drives a synchronous glyph ROM and emits text_on/text_field.
module score_overlay #(
   parameter int N_FIELDS = 4,
   parameter int SCORE_W  = 11,
   parameter int DIGITS   = 3,
   parameter int ORIGIN_X = 0,
   parameter int ORIGIN_Y = 0,
   parameter int SCALE    = 1
) (
   input  logic                                         Clk,
   input  logic                                         Reset_n,
   input  logic                                         frame_start,
   input  logic [N_FIELDS*SCORE_W-1:0]                  scores,
   input  logic                                         blank_lz,
   input  logic [9:0]                                   DrawX,
   input  logic [9:0]                                   DrawY,
   output logic [9:0]                                   rom_addr,
   input  logic [7:0]                                   rom_data,
   output logic                                         text_on,
   output logic [((N_FIELDS > 1) ? $clog2(N_FIELDS) : 1)-1:0] text_field,
   output logic                                         conv_busy
);

   localparam int FW    = (N_FIELDS > 1) ? $clog2(N_FIELDS) : 1;
   localparam int BCD_W = 4 * DIGITS;
   localparam int CW    = $clog2(SCORE_W + 1);
   localparam int SH    = (SCALE == 4) ? 2 : ((SCALE == 2) ? 1 : 0);

   function automatic int pow10(input int n);
      int r;
      r = 1;
      for (int i = 0; i < n; i++) r = r * 10;
      return r;
   endfunction

   localparam logic [31:0] MAXV = 32'(pow10(DIGITS) - 1);

   typedef enum logic [1:0] {IDLE, LOAD, SHIFT, STORE} state_t;

   state_t             state_q, state_d;
   logic [SCORE_W-1:0] snap_q  [N_FIELDS];
   logic [BCD_W-1:0]   digit_q [N_FIELDS];
   logic [FW-1:0]      idx_q;
   logic [SCORE_W-1:0] bin_q;
   logic [BCD_W-1:0]   bcd_q;
   logic [CW-1:0]      cnt_q;
   logic [BCD_W-1:0]   bcd_adj;
   logic [SCORE_W-1:0] snap_sel;
   logic               sat;

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) state_q <= IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (frame_start) state_d = LOAD;
         LOAD:    state_d = SHIFT;
         SHIFT:   if (cnt_q == CW'(SCORE_W - 1)) state_d = STORE;
         STORE:   state_d = (idx_q == FW'(N_FIELDS - 1)) ? IDLE : LOAD;
         default: state_d = IDLE;
      endcase
   end

   assign conv_busy = (state_q != IDLE);

   // Double-dabble correction; digits beyond DIGITS only matter when saturating.
   always_comb begin
      bcd_adj = bcd_q;
      for (int i = 0; i < DIGITS; i++) begin
         if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
      snap_sel = '0;
      for (int k = 0; k < N_FIELDS; k++) begin
         if (idx_q == FW'(k)) snap_sel = snap_q[k];
      end
      sat = (32'(snap_sel) > MAXV);
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         for (int k = 0; k < N_FIELDS; k++) begin
            snap_q[k]  <= '0;
            digit_q[k] <= '0;
         end
         idx_q <= '0;
         bin_q <= '0;
         bcd_q <= '0;
         cnt_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (frame_start) begin
                  for (int k = 0; k < N_FIELDS; k++) snap_q[k] <= scores[k*SCORE_W +: SCORE_W];
                  idx_q <= '0;
               end
            end
            LOAD: begin
               bin_q <= snap_sel;
               bcd_q <= '0;
               cnt_q <= '0;
            end
            SHIFT: begin
               bcd_q <= {bcd_adj[BCD_W-2:0], bin_q[SCORE_W-1]};
               bin_q <= {bin_q[SCORE_W-2:0], 1'b0};
               cnt_q <= cnt_q + 1'b1;
            end
            STORE: begin
               for (int k = 0; k < N_FIELDS; k++) begin
                  if (idx_q == FW'(k)) digit_q[k] <= sat ? {DIGITS{4'h9}} : bcd_q;
               end
               if (idx_q != FW'(N_FIELDS - 1)) idx_q <= idx_q + 1'b1;
            end
            default: ;
         endcase
      end
   end

   int               xi, yi, u, v, p, fi;
   logic             hit_d;
   logic [BCD_W-1:0] dsel;
   logic [3:0]       dig;
   logic             lz;
   logic [5:0]       code;
   logic [9:0]       addr_d;
   logic [2:0]       col_d;
   logic [FW-1:0]    fld_d;

   // Stage 0: locate the pixel in the text block and pick the glyph for that cell.
   always_comb begin
      xi    = int'(DrawX);
      yi    = int'(DrawY);
      hit_d = (xi >= ORIGIN_X) && (xi < ORIGIN_X + DIGITS*8*SCALE) &&
              (yi >= ORIGIN_Y) && (yi < ORIGIN_Y + N_FIELDS*16*SCALE);
      u     = (xi - ORIGIN_X) >>> SH;
      v     = (yi - ORIGIN_Y) >>> SH;
      p     = u >>> 3;
      fi    = v >>> 4;
      dsel  = '0;
      for (int k = 0; k < N_FIELDS; k++) begin
         if (k == fi) dsel = digit_q[k];
      end
      dig = '0;
      lz  = 1'b1;
      for (int k = 0; k < DIGITS; k++) begin
         if (k == p) dig = dsel[4*(DIGITS-1-k) +: 4];
         if ((k <= p) && (dsel[4*(DIGITS-1-k) +: 4] != 4'd0)) lz = 1'b0;
      end
      code   = (blank_lz && lz && (p != DIGITS - 1)) ? 6'd0 : 6'h1b + {2'b00, dig};
      addr_d = hit_d ? {code, v[3:0]} : 10'd0;
      col_d  = hit_d ? u[2:0] : 3'd0;
      fld_d  = hit_d ? FW'(fi) : '0;
   end

   logic          hit_q, hit2_q;
   logic [2:0]    col_q, col2_q;
   logic [FW-1:0] fld_q, fld2_q;
   logic [9:0]    rom_addr_q;
   logic          text_on_q;
   logic [FW-1:0] text_field_q;

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         rom_addr_q   <= '0;
         hit_q        <= 1'b0;
         col_q        <= '0;
         fld_q        <= '0;
         hit2_q       <= 1'b0;
         col2_q       <= '0;
         fld2_q       <= '0;
         text_on_q    <= 1'b0;
         text_field_q <= '0;
      end else begin
         rom_addr_q   <= addr_d;
         hit_q        <= hit_d;
         col_q        <= col_d;
         fld_q        <= fld_d;
         hit2_q       <= hit_q;
         col2_q       <= col_q;
         fld2_q       <= fld_q;
         text_on_q    <= hit2_q & rom_data[3'd7 - col2_q];
         text_field_q <= hit2_q ? fld2_q : '0;
      end
   end

   assign rom_addr   = rom_addr_q;
   assign text_on    = text_on_q;
   assign text_field = text_field_q;

endmodule
